// File: rtl/scalar_reg_wb_arbiter.sv
// Writeback arbiter for the scalar register file.
// It uses independent round-robin arbiters for the integer and FP write ports, and registers the write outputs.
module scalar_reg_wb_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int SCALAR_REG_WIDTH = 64,
    parameter int SCALAR_REG_DEPTH = 32,
    localparam int AW = $clog2(SCALAR_REG_DEPTH),
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wb_stall,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_fp,
    input  logic [NUM_REQ*AW-1:0]               req_addr,
    input  logic [NUM_REQ*SCALAR_REG_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                write,
    output logic [AW-1:0]                       wr_access_ptr,
    output logic [SCALAR_REG_WIDTH-1:0]         write_data,
    output logic                                fwrite,
    output logic [AW-1:0]                       wr_faccess_ptr,
    output logic [SCALAR_REG_WIDTH-1:0]         fwrite_data
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PW-1:0]               int_prio_q, int_prio_d;
    logic [PW-1:0]               fp_prio_q, fp_prio_d;
    logic [NUM_REQ-1:0]          int_cand, fp_cand;
    logic                        int_hit, fp_hit;
    logic                        int_go, fp_go;
    logic [PW-1:0]               int_gnt, fp_gnt;
    int unsigned                 pos;

    logic                        write_q, write_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [SCALAR_REG_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                        fwrite_q, fwrite_d;
    logic [AW-1:0]               fwr_ptr_q, fwr_ptr_d;
    logic [SCALAR_REG_WIDTH-1:0] fwr_data_q, fwr_data_d;

    always_comb begin
        int_cand = req_valid & ~req_fp;
        fp_cand  = req_valid & req_fp;
        int_hit  = 1'b0;
        fp_hit   = 1'b0;
        int_gnt  = '0;
        fp_gnt   = '0;
        pos      = 0;
        // Scan from each domain's pointer; the first hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(int_prio_q) + k) % NUM_REQ;
            if (!int_hit && int_cand[PW'(pos)]) begin
                int_hit = 1'b1;
                int_gnt = PW'(pos);
            end
            pos = (32'(fp_prio_q) + k) % NUM_REQ;
            if (!fp_hit && fp_cand[PW'(pos)]) begin
                fp_hit = 1'b1;
                fp_gnt = PW'(pos);
            end
        end
        int_go = int_hit & ~wb_stall & reset;
        fp_go  = fp_hit & ~wb_stall & reset;

        req_ready = ({NUM_REQ{int_go}} & (ONE << int_gnt))
                  | ({NUM_REQ{fp_go}} & (ONE << fp_gnt));

        int_prio_d = int_prio_q;
        fp_prio_d  = fp_prio_q;
        if (int_go)
            int_prio_d = (int_gnt == PW'(NUM_REQ-1)) ? '0 : int_gnt + PW'(1);
        if (fp_go)
            fp_prio_d = (fp_gnt == PW'(NUM_REQ-1)) ? '0 : fp_gnt + PW'(1);

        write_d    = int_go;
        wr_ptr_d   = wr_ptr_q;
        wr_data_d  = wr_data_q;
        fwrite_d   = fp_go;
        fwr_ptr_d  = fwr_ptr_q;
        fwr_data_d = fwr_data_q;
        if (int_go) begin
            wr_ptr_d  = req_addr[32'(int_gnt)*AW +: AW];
            wr_data_d = req_data[32'(int_gnt)*SCALAR_REG_WIDTH +: SCALAR_REG_WIDTH];
        end
        if (fp_go) begin
            fwr_ptr_d  = req_addr[32'(fp_gnt)*AW +: AW];
            fwr_data_d = req_data[32'(fp_gnt)*SCALAR_REG_WIDTH +: SCALAR_REG_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_prio_q <= '0;
            fp_prio_q  <= '0;
            write_q    <= 1'b0;
            wr_ptr_q   <= '0;
            wr_data_q  <= '0;
            fwrite_q   <= 1'b0;
            fwr_ptr_q  <= '0;
            fwr_data_q <= '0;
        end else begin
            int_prio_q <= int_prio_d;
            fp_prio_q  <= fp_prio_d;
            write_q    <= write_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_data_q  <= wr_data_d;
            fwrite_q   <= fwrite_d;
            fwr_ptr_q  <= fwr_ptr_d;
            fwr_data_q <= fwr_data_d;
        end
    end

    assign write          = write_q;
    assign wr_access_ptr  = wr_ptr_q;
    assign write_data     = wr_data_q;
    assign fwrite         = fwrite_q;
    assign wr_faccess_ptr = fwr_ptr_q;
    assign fwrite_data    = fwr_data_q;

endmodule

// File: tb/tb_scalar_reg_wb_arbiter.sv
// Directed self-checking bench for scalar_reg_wb_arbiter with default parameters.
module tb_scalar_reg_wb_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wb_stall = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_fp = '0;
    logic [N*AW-1:0]  req_addr = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             write, fwrite;
    logic [AW-1:0]    wr_access_ptr, wr_faccess_ptr;
    logic [W-1:0]     write_data, fwrite_data;

    int tests = 0;
    int fails = 0;

    scalar_reg_wb_arbiter #(
        .NUM_REQ(N),
        .SCALAR_REG_WIDTH(W),
        .SCALAR_REG_DEPTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_stall(wb_stall),
        .req_valid(req_valid),
        .req_fp(req_fp),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .write(write),
        .wr_access_ptr(wr_access_ptr),
        .write_data(write_data),
        .fwrite(fwrite),
        .wr_faccess_ptr(wr_faccess_ptr),
        .fwrite_data(fwrite_data)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic fp,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]         = v;
        req_fp[i]            = fp;
        req_addr[i*AW +: AW] = a;
        req_data[i*W +: W]   = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_fp    = '0;
        req_addr  = '0;
        req_data  = '0;
        wb_stall  = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_fp    = 4'b0101;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        tests++; if (write !== 1'b0 || fwrite !== 1'b0) begin fails++; $display("FAIL reset_strobes got=%b%b exp=00", write, fwrite); end
        tests++; if (wr_access_ptr !== '0 || wr_faccess_ptr !== '0) begin fails++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", wr_access_ptr, wr_faccess_ptr); end
        tests++; if (write_data !== '0 || fwrite_data !== '0) begin fails++; $display("FAIL reset_data got=%h/%h exp=0/0", write_data, fwrite_data); end
        clear_reqs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_int();
        do_reset();
        @(posedge clk); #1;
        set_req(2, 1'b1, 1'b0, 5'd5, 64'hDEAD_BEEF);
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        tests++; if (write !== 1'b1) begin fails++; $display("FAIL single_write got=%b exp=1", write); end
        tests++; if (wr_access_ptr !== 5'd5) begin fails++; $display("FAIL single_ptr got=%0d exp=5", wr_access_ptr); end
        tests++; if (write_data !== 64'hDEAD_BEEF) begin fails++; $display("FAIL single_data got=%h exp=deadbeef", write_data); end
        tests++; if (fwrite !== 1'b0) begin fails++; $display("FAIL single_fwrite got=%b exp=0", fwrite); end
        @(posedge clk); #1;
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL single_write_drop got=%b exp=0", write); end
        tests++; if (wr_access_ptr !== 5'd5 || write_data !== 64'hDEAD_BEEF) begin fails++; $display("FAIL single_hold got=%0d/%h exp=5/deadbeef", wr_access_ptr, write_data); end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 5'(i + 8), 64'h100 + 64'(i));
        for (int k = 0; k < 8; k++) begin
            g = k % N;
            #1;
            tests++; if (req_ready !== 4'(1 << g)) begin fails++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << g)); end
            @(posedge clk); #1;
            tests++; if (write !== 1'b1 || wr_access_ptr !== 5'(g + 8) || write_data !== 64'h100 + 64'(g)) begin
                fails++; $display("FAIL rr_write k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, write, wr_access_ptr, write_data, g + 8, 64'h100 + 64'(g));
            end
            tests++; if (fwrite !== 1'b0) begin fails++; $display("FAIL rr_fwrite k=%0d got=%b exp=0", k, fwrite); end
        end
        req_valid = '0;
        @(posedge clk); #1;
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL rr_end_write got=%b exp=0", write); end
    endtask

    task automatic test_dual();
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 5'd1, 64'hAAAA_0000_1111_2222);
        set_req(1, 1'b1, 1'b1, 5'd1, 64'hBBBB_3333_4444_5555);
        #1;
        tests++; if (req_ready !== 4'b0011) begin fails++; $display("FAIL dual_ready got=%b exp=0011", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        tests++; if (write !== 1'b1 || wr_access_ptr !== 5'd1 || write_data !== 64'hAAAA_0000_1111_2222) begin
            fails++; $display("FAIL dual_int got=%b/%0d/%h exp=1/1/aaaa000011112222", write, wr_access_ptr, write_data);
        end
        tests++; if (fwrite !== 1'b1 || wr_faccess_ptr !== 5'd1 || fwrite_data !== 64'hBBBB_3333_4444_5555) begin
            fails++; $display("FAIL dual_fp got=%b/%0d/%h exp=1/1/bbbb333344445555", fwrite, wr_faccess_ptr, fwrite_data);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(posedge clk); #1;
        wb_stall = 1'b1;
        set_req(1, 1'b1, 1'b0, 5'd11, 64'h11);
        set_req(3, 1'b1, 1'b0, 5'd13, 64'h33);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready k=%0d got=%b exp=0000", k, req_ready); end
            @(posedge clk); #1;
            tests++; if (write !== 1'b0) begin fails++; $display("FAIL stall_write k=%0d got=%b exp=0", k, write); end
        end
        wb_stall = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stall_rel_first got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        tests++; if (write !== 1'b1 || wr_access_ptr !== 5'd11) begin fails++; $display("FAIL stall_rel_w1 got=%b/%0d exp=1/11", write, wr_access_ptr); end
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL stall_rel_second got=%b exp=1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        tests++; if (write !== 1'b1 || wr_access_ptr !== 5'd13) begin fails++; $display("FAIL stall_rel_w2 got=%b/%0d exp=1/13", write, wr_access_ptr); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(posedge clk); #1;
        set_req(3, 1'b1, 1'b0, 5'd23, 64'h3333);
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL wrap_first got=%b exp=1000", req_ready); end
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 5'd20, 64'h0000_0000_0000_0A0A);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        tests++; if (write !== 1'b1 || wr_access_ptr !== 5'd20 || write_data !== 64'hA0A) begin
            fails++; $display("FAIL wrap_write got=%b/%0d/%h exp=1/20/a0a", write, wr_access_ptr, write_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 5'd3, 64'hC0);
        set_req(1, 1'b1, 1'b0, 5'd4, 64'hC1);
        set_req(2, 1'b1, 1'b1, 5'd7, 64'hF2);
        @(posedge clk); #1;
        tests++; if (write !== 1'b1 || fwrite !== 1'b1) begin fails++; $display("FAIL mid_pre got=%b%b exp=11", write, fwrite); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (write !== 1'b0 || fwrite !== 1'b0) begin fails++; $display("FAIL mid_strobes got=%b%b exp=00", write, fwrite); end
        tests++; if (wr_access_ptr !== '0 || wr_faccess_ptr !== '0 || write_data !== '0 || fwrite_data !== '0) begin
            fails++; $display("FAIL mid_outs got=%0d/%0d/%h/%h exp=0/0/0/0", wr_access_ptr, wr_faccess_ptr, write_data, fwrite_data);
        end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        tests++; if (write !== 1'b0 || fwrite !== 1'b0) begin fails++; $display("FAIL mid_inflight got=%b%b exp=00", write, fwrite); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0101) begin fails++; $display("FAIL mid_prio_reset got=%b exp=0101", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        tests++; if (write !== 1'b1 || wr_access_ptr !== 5'd3 || fwrite !== 1'b1 || wr_faccess_ptr !== 5'd7) begin
            fails++; $display("FAIL mid_after got=%b/%0d/%b/%0d exp=1/3/1/7", write, wr_access_ptr, fwrite, wr_faccess_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_single_int();
        test_round_robin();
        test_dual();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
